// File: rtl/vend_ctrl_multi_if.sv
// ============================================================================
//  Module      : vend_ctrl_multi_if
//  Description : Button/coin inputs and display/dispense outputs of the
//                multi-item vending controller, bundled as one interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vend_ctrl_multi_if #(
    parameter int N_ITEMS  = 3,
    parameter int CREDIT_W = 8
);
    logic                cancel;
    logic                coin_5;
    logic                coin_10;
    logic                coin_50;
    logic [N_ITEMS-1:0]  sel;
    logic                restock;
    logic [CREDIT_W-1:0] credit;
    logic [N_ITEMS-1:0]  avail;
    logic [N_ITEMS-1:0]  stock_empty;
    logic [N_ITEMS-1:0]  drop;
    logic                change_out;
    logic                coin_reject;
    logic                busy;

    modport master (
        output cancel, coin_5, coin_10, coin_50, sel, restock,
        input  credit, avail, stock_empty, drop, change_out, coin_reject, busy
    );

    modport slave (
        input  cancel, coin_5, coin_10, coin_50, sel, restock,
        output credit, avail, stock_empty, drop, change_out, coin_reject, busy
    );
endinterface

`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
// ============================================================================
//  Module      : vend_ctrl_multi
//  Description : Vending controller with per-item price/stock, coin acceptance
//                up to a credit ceiling, single-item vend and unit-coin change.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vend_ctrl_multi #(
    parameter int                          N_ITEMS    = 3,
    parameter int                          CREDIT_W   = 8,
    parameter int                          MAX_CREDIT = 50,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15},
    parameter int                          COIN_UNIT  = 5,
    parameter int                          STOCK_W    = 4,
    parameter int                          STOCK_INIT = 10
) (
    input  logic              clk,
    input  logic              rst,
    vend_ctrl_multi_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0]   MAX_SUM  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   VAL_5    = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W:0]   VAL_10   = (CREDIT_W+1)'(10);
    localparam logic [CREDIT_W:0]   VAL_50   = (CREDIT_W+1)'(50);
    localparam logic [CREDIT_W-1:0] UNIT     = CREDIT_W'(COIN_UNIT);
    localparam logic [STOCK_W-1:0]  STOCK_LD = STOCK_W'(STOCK_INIT);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit, credit_nxt;
    logic [N_ITEMS-1:0]  drop, drop_nxt;
    logic                change_out, change_nxt;
    logic                coin_reject, reject_nxt;
    logic [N_ITEMS-1:0]  dec;
    logic [N_ITEMS-1:0]  avail;
    logic [N_ITEMS-1:0]  stock_empty;
    logic [CREDIT_W-1:0] price [N_ITEMS];
    logic [STOCK_W-1:0]  stock [N_ITEMS];
    logic [CREDIT_W-1:0] price_sel;
    logic                sel_valid;
    logic                coin_any;
    logic                coin_multi;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;

    generate
        for (genvar i = 0; i < N_ITEMS; i++) begin : g_items
            assign price[i]       = PRICES[i*CREDIT_W +: CREDIT_W];
            assign stock_empty[i] = (stock[i] == '0);
            assign avail[i]       = (credit >= price[i]) && !stock_empty[i] && (state == IDLE);

            // restock takes precedence over a decrement in the same cycle
            always_ff @(posedge clk) begin
                if (rst || bus.restock) begin
                    stock[i] <= STOCK_LD;
                end else if (dec[i]) begin
                    stock[i] <= stock[i] - STOCK_W'(1);
                end
            end
        end
    endgenerate

    assign coin_any   = bus.coin_5 | bus.coin_10 | bus.coin_50;
    assign coin_multi = (bus.coin_5 & bus.coin_10) | (bus.coin_5 & bus.coin_50) |
                        (bus.coin_10 & bus.coin_50);
    assign coin_val   = bus.coin_5 ? VAL_5 : (bus.coin_10 ? VAL_10 : VAL_50);
    assign coin_sum   = {1'b0, credit} + coin_val;
    assign sel_valid  = $onehot(bus.sel) && ((bus.sel & avail) != '0);

    always_comb begin
        price_sel = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (bus.sel[i]) begin
                price_sel = price_sel | price[i];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        drop_nxt   = '0;
        reject_nxt = 1'b0;
        dec        = '0;
        case (state)
            IDLE: begin
                if (bus.cancel) begin
                    reject_nxt = coin_any;
                    if (credit != '0) begin
                        state_nxt = CHANGE;
                    end
                end else if (coin_any) begin
                    // the priority winner may still be credited while losers bounce
                    if (coin_sum <= MAX_SUM) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        reject_nxt = coin_multi;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end else if (sel_valid) begin
                    credit_nxt = credit - price_sel;
                    dec        = bus.sel;
                    drop_nxt   = bus.sel;
                    state_nxt  = VEND;
                end
            end
            VEND: begin
                reject_nxt = coin_any;
                state_nxt  = (credit == '0) ? IDLE : CHANGE;
            end
            CHANGE: begin
                reject_nxt = coin_any;
                if (credit <= UNIT) begin
                    credit_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    credit_nxt = credit - UNIT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // change_out is high for exactly the cycles spent in CHANGE
        change_nxt = (state_nxt == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            drop        <= '0;
            change_out  <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            drop        <= drop_nxt;
            change_out  <= change_nxt;
            coin_reject <= reject_nxt;
        end
    end

    assign bus.credit      = credit;
    assign bus.avail       = avail;
    assign bus.stock_empty = stock_empty;
    assign bus.drop        = drop;
    assign bus.change_out  = change_out;
    assign bus.coin_reject = coin_reject;
    assign bus.busy        = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
// ============================================================================
//  Module      : tb_vend_ctrl_multi
//  Description : Directed self-checking bench for vend_ctrl_multi (STOCK_INIT=2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vend_ctrl_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   asserts  = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vend_ctrl_multi_if #(.N_ITEMS(3), .CREDIT_W(8)) bus ();

    vend_ctrl_multi #(
        .N_ITEMS   (3),
        .CREDIT_W  (8),
        .MAX_CREDIT(50),
        .PRICES    ({8'd25, 8'd20, 8'd15}),
        .COIN_UNIT (5),
        .STOCK_W   (4),
        .STOCK_INIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cancel  = 1'b0;
        bus.coin_5  = 1'b0;
        bus.coin_10 = 1'b0;
        bus.coin_50 = 1'b0;
        bus.sel     = 3'b000;
        bus.restock = 1'b0;
    endtask

    // code: 5, 10 or 50
    task automatic coin(input int code);
        bus.coin_5  = (code == 5);
        bus.coin_10 = (code == 10);
        bus.coin_50 = (code == 50);
        tick();
        clear_inputs();
    endtask

    // Counts change_out pulses from the current sample until busy drops.
    task automatic drain(output int pulses, output bit done);
        pulses = 0;
        done   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.change_out) pulses++;
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        asserts++;
        if (bus.credit !== 8'd0) begin failures++; $display("FAIL reset_credit: got %0d expected 0", bus.credit); end
        asserts++;
        if ({bus.busy, bus.change_out, bus.coin_reject, bus.drop} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs: got busy=%b chg=%b rej=%b drop=%b expected all 0",
                                 bus.busy, bus.change_out, bus.coin_reject, bus.drop);
        end
        asserts++;
        if (bus.stock_empty !== 3'b000 || bus.avail !== 3'b000) begin
            failures++; $display("FAIL reset_stock: got empty=%b avail=%b expected 000/000", bus.stock_empty, bus.avail);
        end
        tick();
        asserts++;
        if ({bus.change_out, bus.coin_reject, bus.drop} !== 5'b0) begin
            failures++; $display("FAIL post_reset_pulses: got chg=%b rej=%b drop=%b expected 0", bus.change_out, bus.coin_reject, bus.drop);
        end
    endtask

    task automatic test_exact_buy();
        coin(5);
        asserts++;
        if (bus.credit !== 8'd5) begin failures++; $display("FAIL buy_credit5: got %0d expected 5", bus.credit); end
        coin(10);
        asserts++;
        if (bus.credit !== 8'd15) begin failures++; $display("FAIL buy_credit15: got %0d expected 15", bus.credit); end
        coin(10);
        asserts++;
        if (bus.credit !== 8'd25 || bus.avail !== 3'b111) begin
            failures++; $display("FAIL buy_credit25: got credit=%0d avail=%b expected 25/111", bus.credit, bus.avail);
        end
        bus.sel = 3'b100;
        tick();
        clear_inputs();
        asserts++;
        if (bus.drop !== 3'b100 || bus.credit !== 8'd0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL buy_drop: got drop=%b credit=%0d busy=%b expected 100/0/1", bus.drop, bus.credit, bus.busy);
        end
        tick();
        asserts++;
        if (bus.drop !== 3'b000 || bus.busy !== 1'b0 || bus.change_out !== 1'b0) begin
            failures++; $display("FAIL buy_after: got drop=%b busy=%b chg=%b expected 000/0/0", bus.drop, bus.busy, bus.change_out);
        end
    endtask

    task automatic test_vend_change();
        int  p;
        bit  ok;
        coin(50);
        bus.sel = 3'b001;
        tick();
        clear_inputs();
        asserts++;
        if (bus.drop !== 3'b001 || bus.credit !== 8'd35) begin
            failures++; $display("FAIL change_drop: got drop=%b credit=%0d expected 001/35", bus.drop, bus.credit);
        end
        drain(p, ok);
        asserts++;
        if (!ok || p != 7) begin failures++; $display("FAIL change_pulses: got %0d done=%b expected 7 done=1", p, ok); end
        asserts++;
        if (bus.credit !== 8'd0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL change_end: got credit=%0d busy=%b expected 0/0", bus.credit, bus.busy);
        end
    endtask

    task automatic test_coin_reject();
        int p;
        bit ok;
        for (int k = 0; k < 4; k++) coin(10);
        coin(5);
        coin(10);
        asserts++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd45) begin
            failures++; $display("FAIL reject_overflow: got rej=%b credit=%0d expected 1/45", bus.coin_reject, bus.credit);
        end
        tick();
        asserts++;
        if (bus.coin_reject !== 1'b0) begin failures++; $display("FAIL reject_width: got %b expected 0", bus.coin_reject); end
        coin(5);
        asserts++;
        if (bus.credit !== 8'd50 || bus.coin_reject !== 1'b0) begin
            failures++; $display("FAIL reject_fill50: got credit=%0d rej=%b expected 50/0", bus.credit, bus.coin_reject);
        end
        bus.coin_5  = 1'b1;
        bus.coin_10 = 1'b1;
        tick();
        clear_inputs();
        asserts++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd50) begin
            failures++; $display("FAIL reject_dual: got rej=%b credit=%0d expected 1/50", bus.coin_reject, bus.credit);
        end
        bus.cancel = 1'b1;
        tick();
        clear_inputs();
        drain(p, ok);
        asserts++;
        if (!ok || p != 10) begin failures++; $display("FAIL reject_refund: got %0d done=%b expected 10 done=1", p, ok); end
    endtask

    task automatic test_stock_out();
        int p;
        bit ok;
        coin(50);
        bus.sel = 3'b001;
        tick();
        clear_inputs();
        drain(p, ok);
        asserts++;
        if (!ok || p != 7 || bus.stock_empty !== 3'b001) begin
            failures++; $display("FAIL stock_second_vend: got pulses=%0d empty=%b expected 7/001", p, bus.stock_empty);
        end
        coin(50);
        asserts++;
        if (bus.avail !== 3'b110) begin failures++; $display("FAIL stock_avail: got %b expected 110", bus.avail); end
        bus.sel = 3'b001;
        tick();
        clear_inputs();
        asserts++;
        if (bus.drop !== 3'b000 || bus.busy !== 1'b0 || bus.credit !== 8'd50) begin
            failures++; $display("FAIL stock_sel_ignored: got drop=%b busy=%b credit=%0d expected 000/0/50", bus.drop, bus.busy, bus.credit);
        end
        bus.restock = 1'b1;
        tick();
        clear_inputs();
        asserts++;
        if (bus.avail !== 3'b111 || bus.stock_empty !== 3'b000) begin
            failures++; $display("FAIL stock_restock: got avail=%b empty=%b expected 111/000", bus.avail, bus.stock_empty);
        end
        bus.cancel = 1'b1;
        tick();
        clear_inputs();
        drain(p, ok);
    endtask

    task automatic test_reset_mid_change();
        int p;
        p = 0;
        for (int k = 0; k < 3; k++) coin(10);
        bus.cancel = 1'b1;
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            if (bus.change_out) p++;
            if (k < 2) tick();
        end
        asserts++;
        if (p != 3 || bus.credit !== 8'd20) begin
            failures++; $display("FAIL midreset_pulses: got pulses=%0d credit=%0d expected 3/20", p, bus.credit);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        asserts++;
        if (bus.credit !== 8'd0 || bus.busy !== 1'b0 || bus.change_out !== 1'b0) begin
            failures++; $display("FAIL midreset_state: got credit=%0d busy=%b chg=%b expected 0/0/0", bus.credit, bus.busy, bus.change_out);
        end
        tick();
        asserts++;
        if (bus.change_out !== 1'b0 || bus.credit !== 8'd0) begin
            failures++; $display("FAIL midreset_after: got chg=%b credit=%0d expected 0/0", bus.change_out, bus.credit);
        end
    endtask

    task automatic test_cancel_and_ignore();
        int p;
        bit ok;
        bus.cancel = 1'b1;
        tick();
        clear_inputs();
        asserts++;
        if (bus.busy !== 1'b0 || bus.change_out !== 1'b0 || bus.credit !== 8'd0 || bus.coin_reject !== 1'b0) begin
            failures++; $display("FAIL cancel_zero: got busy=%b chg=%b credit=%0d rej=%b expected 0/0/0/0",
                                 bus.busy, bus.change_out, bus.credit, bus.coin_reject);
        end
        coin(10);
        coin(10);
        bus.cancel = 1'b1;
        tick();
        clear_inputs();
        bus.sel     = 3'b010;
        bus.coin_10 = 1'b1;
        tick();
        clear_inputs();
        asserts++;
        if (bus.coin_reject !== 1'b1 || bus.drop !== 3'b000 || bus.credit !== 8'd15 || bus.change_out !== 1'b1) begin
            failures++; $display("FAIL change_ignore: got rej=%b drop=%b credit=%0d chg=%b expected 1/000/15/1",
                                 bus.coin_reject, bus.drop, bus.credit, bus.change_out);
        end
        drain(p, ok);
        asserts++;
        if (!ok || p != 3 || bus.credit !== 8'd0 || bus.stock_empty !== 3'b000) begin
            failures++; $display("FAIL change_ignore_end: got pulses=%0d credit=%0d empty=%b expected 3/0/000",
                                 p, bus.credit, bus.stock_empty);
        end
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_exact_buy();
        test_vend_change();
        test_coin_reject();
        test_stock_out();
        test_reset_mid_change();
        test_cancel_and_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

`default_nettype wire
